uart_cmd_responder: RTL and testbench

Byte-level command responder on the far side of the UART link: consumes bytes delivered by the UART receiver, decodes a 2/3-byte read/write command protocol, performs accesses on a small register bus, and returns one response byte through the UART transmitter. It sits between `uart_rx_tx_only` (rx_dout/rx_done_tick in, tx_din/tx_start/tx_done_tick out) and a register file, giving a host PC register access over serial.

---
 rtl/uart_cmd_pkg.sv | 20 ++
 rtl/cmd_timeout_counter.sv | 27 ++
 rtl/uart_cmd_responder.sv | 102 ++++++++++
 tb/tb_uart_cmd_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared protocol constants and FSM state type for the UART command responder.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    READ_CAP,
    SEND,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/cmd_timeout_counter.sv
// Inter-byte timeout counter: counts enabled cycles, pulses expire at TIMEOUT-1.
module cmd_timeout_counter #(
  parameter int TIMEOUT = 1_000_000,
  parameter int TO_BITS = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TO_BITS-1:0] count;

  assign expire = enable && (count == TO_BITS'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TO_BITS'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes 'W' addr data / 'R' addr commands from the UART receiver, drives the
// register bus and returns one response byte through the UART transmitter.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int D_BITS  = 8,
  parameter int TIMEOUT = 1_000_000,
  parameter int TO_BITS = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_done_tick,
  input  logic [D_BITS-1:0] rx_dout,
  output logic              tx_start,
  output logic [D_BITS-1:0] tx_din,
  input  logic              tx_done_tick,
  output logic [D_BITS-1:0] reg_addr,
  output logic [D_BITS-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [D_BITS-1:0] reg_rdata,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_drop
);

  state_t state, state_next;
  logic   op_write;
  logic   is_write, is_read;
  logic   collecting;
  logic   to_expire;

  assign is_write   = (rx_dout == D_BITS'(OP_WRITE));
  assign is_read    = (rx_dout == D_BITS'(OP_READ));
  assign collecting = (state == GET_ADDR) || (state == GET_DATA);

  // Counter is held clear outside the byte-collecting states, so entry starts at 0.
  cmd_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .TO_BITS (TO_BITS)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!collecting || rx_done_tick),
    .enable  (collecting),
    .expire  (to_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (rx_done_tick) state_next = (is_write || is_read) ? GET_ADDR : SEND;
      GET_ADDR:  if (rx_done_tick)   state_next = op_write ? GET_DATA : READ;
                 else if (to_expire) state_next = IDLE;
      GET_DATA:  if (rx_done_tick)   state_next = WRITE;
                 else if (to_expire) state_next = IDLE;
      WRITE:     state_next = SEND;
      READ:      state_next = READ_CAP;
      READ_CAP:  state_next = SEND;
      SEND:      state_next = WAIT_DONE;
      WAIT_DONE: if (tx_done_tick) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Byte latches and response register; tx_din only changes before SEND.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_write  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      tx_din    <= '0;
    end else begin
      case (state)
        IDLE: if (rx_done_tick) begin
          op_write <= is_write;
          if (!is_write && !is_read) tx_din <= D_BITS'(RSP_ERR);
        end
        GET_ADDR: if (rx_done_tick) reg_addr  <= rx_dout;
        GET_DATA: if (rx_done_tick) reg_wdata <= rx_dout;
        WRITE:    tx_din <= D_BITS'(RSP_ACK);
        READ_CAP: tx_din <= reg_rdata;
        default:  ;
      endcase
    end
  end

  always_comb begin
    reg_we      = (state == WRITE);
    reg_re      = (state == READ);
    tx_start    = (state == SEND);
    busy        = (state != IDLE);
    err_timeout = to_expire && !rx_done_tick;
    err_drop    = rx_done_tick && (state != IDLE) && !collecting;
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench: a cycle-indexed expectation timeline built from the command
// protocol rules is compared against the DUT outputs on every cycle.
module tb_uart_cmd_responder;

  localparam int TO    = 50;
  localparam int N     = 2048;
  localparam int TXLAT = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       tx_done_tick = 1'b0;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy, err_timeout, err_drop;

  uart_cmd_responder #(.D_BITS(8), .TIMEOUT(TO), .TO_BITS(20)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_we       (reg_we),
    .reg_re       (reg_re),
    .reg_rdata    (reg_rdata),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_drop     (err_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Register-file peripheral on the bus (stimulus side).
  logic [7:0] bench_mem [256] = '{7: 8'h3C, default: 8'h00};
  always @(posedge clk) begin
    if (reg_we) bench_mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= bench_mem[reg_addr];
  end

  // Behavioural model: expected outputs per cycle.
  bit         e_we [N], e_re [N], e_start [N], e_to [N], e_drop [N], e_busy [N];
  logic [7:0] e_addr [N], e_wdata [N], e_din [N];
  logic [7:0] mmem [256] = '{7: 8'h3C, default: 8'h00};
  logic [7:0] cmd [$];
  bit         collecting = 1'b0;
  bit         responding = 1'b0;
  int         deadline = 0;
  int         last_t = 0;

  function automatic void fill_busy(int from, bit v);
    for (int i = from; i < N; i++) e_busy[i] = v;
  endfunction

  function automatic void respond(int s, logic [7:0] v);
    collecting = 1'b0;
    cmd.delete();
    responding = 1'b1;
    if (s < N) begin
      e_start[s] = 1'b1;
      e_din[s]   = v;
    end
  endfunction

  function automatic void model_byte(int t, logic [7:0] b);
    if (responding) begin
      e_drop[t] = 1'b1;
      return;
    end
    if (collecting && t > deadline) begin
      collecting = 1'b0;
      cmd.delete();
    end else if (collecting && deadline < N) begin
      e_to[deadline] = 1'b0;
    end
    cmd.push_back(b);
    fill_busy(t + 1, 1'b1);
    if (cmd[0] != 8'h57 && cmd[0] != 8'h52) begin
      respond(t + 1, 8'h3F);
    end else if (cmd[0] == 8'h57 && cmd.size() == 3) begin
      e_we[t+1] = 1'b1; e_addr[t+1] = cmd[1]; e_wdata[t+1] = cmd[2];
      mmem[cmd[1]] = cmd[2];
      respond(t + 2, 8'h4B);
    end else if (cmd[0] == 8'h52 && cmd.size() == 2) begin
      e_re[t+1] = 1'b1; e_addr[t+1] = cmd[1];
      respond(t + 3, mmem[cmd[1]]);
    end else begin
      collecting = 1'b1;
      deadline   = t + TO;
      if (deadline < N) e_to[deadline] = 1'b1;
      fill_busy(deadline + 1, 1'b0);
    end
  endfunction

  function automatic void model_done(int d);
    if (responding) begin
      responding = 1'b0;
      fill_busy(d + 1, 1'b0);
    end
  endfunction

  function automatic void model_reset(int t);
    for (int i = t; i < N; i++) begin
      e_we[i] = 0; e_re[i] = 0; e_start[i] = 0; e_to[i] = 0; e_drop[i] = 0; e_busy[i] = 0;
    end
    collecting = 1'b0;
    responding = 1'b0;
    cmd.delete();
  endfunction

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (cyc < N) begin
      chk("reg_we", reg_we, e_we[cyc]);
      chk("reg_re", reg_re, e_re[cyc]);
      if (e_we[cyc]) begin
        chk("wr_addr", reg_addr, e_addr[cyc]);
        chk("wr_data", reg_wdata, e_wdata[cyc]);
      end
      if (e_re[cyc]) chk("rd_addr", reg_addr, e_addr[cyc]);
      chk("tx_start", tx_start, e_start[cyc]);
      if (e_start[cyc]) chk("tx_din", tx_din, e_din[cyc]);
      chk("err_timeout", err_timeout, e_to[cyc]);
      chk("err_drop", err_drop, e_drop[cyc]);
      chk("busy", busy, e_busy[cyc]);
    end
  end

  // Transmitter: finishes each started byte TXLAT cycles later.
  initial begin
    logic [7:0] held;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        held = tx_din;
        repeat (TXLAT) @(posedge clk);
        #1 tx_done_tick = 1'b1;
        model_done(cyc);
        chk("tx_din_stable", tx_din, held);
        @(posedge clk);
        #1 tx_done_tick = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_done_tick = 1'b1;
    rx_dout = b;
    last_t = cyc;
    model_byte(cyc, b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rx_done_tick = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tx_start"}, tx_start, 8'h00);
    chk({tag, "_tx_din"}, tx_din, 8'h00);
    chk({tag, "_reg_addr"}, reg_addr, 8'h00);
    chk({tag, "_reg_wdata"}, reg_wdata, 8'h00);
    chk({tag, "_reg_we"}, reg_we, 8'h00);
    chk({tag, "_reg_re"}, reg_re, 8'h00);
    chk({tag, "_busy"}, busy, 8'h00);
    chk({tag, "_err"}, {6'd0, err_timeout, err_drop}, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_w;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    reset_n = 1'b1;
    idle(2);

    // Write 0xA5 to 0x05
    send(8'h57); idle(39); send(8'h05); idle(39); send(8'hA5);
    chk("pin_write_we", e_we[last_t+1], 8'h01);
    chk("pin_write_ack", e_din[last_t+2], 8'h4B);
    idle(30);

    // Read preloaded 0x07
    send(8'h52); idle(9); send(8'h07);
    chk("pin_read_data", e_din[last_t+3], 8'h3C);
    idle(30);

    // Read back the write
    send(8'h52); idle(4); send(8'h05);
    chk("pin_readback", e_din[last_t+3], 8'hA5);
    idle(30);

    // Unknown opcode
    send(8'h11);
    chk("pin_unknown", e_din[last_t+1], 8'h3F);
    idle(30);

    // Timeout after 'W', addr; then a normal read
    send(8'h57); send(8'h05);
    chk("pin_timeout", e_to[last_t+TO], 8'h01);
    idle(60);
    send(8'h52); send(8'h05);
    idle(30);

    // Bytes landing exactly on the expiry cycle are accepted
    send(8'h57); t_w = last_t; idle(TO - 1); send(8'h09);
    chk("pin_expiry_accept", e_to[t_w+TO], 8'h00);
    idle(TO - 1); send(8'h5A);
    chk("pin_expiry_write", e_wdata[last_t+1], 8'h5A);
    idle(30);

    // Extra bytes during READ and WAIT_DONE are dropped
    send(8'h52); send(8'h07); t_w = last_t;
    send(8'hEE); idle(8); send(8'h52);
    chk("pin_drop", e_drop[t_w+10], 8'h01);
    idle(30);

    // Reset between opcode and address
    send(8'h57); idle(5);
    @(posedge clk);
    #3 reset_n = 1'b0;
    model_reset(cyc);
    #1 check_outputs_zero("midreset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    send(8'h05);
    chk("pin_after_reset", e_din[last_t+1], 8'h3F);
    idle(40);

    chk("no_outstanding_response", {7'd0, responding}, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
